mem_bus_arbiter: RTL and testbench

//   Shares the single memory-mapped data bus (RAM/GPIO/UART address decoder) between two masters.

---
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single memory-mapped data bus (RAM/GPIO/UART decoder) between
//   two masters: master 0 is the CPU data port, master 1 is the UART program
//   loader/DMA. Round-robin arbitration on a req/done handshake, one bus
//   transaction at a time, with a timeout for slaves that never answer.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   m0_req/m0_we/m0_addr/m0_wdata   master 0 request (held until m0_done)
//   m0_done             1-cycle completion pulse to master 0
//   m1_*                same as master 0, for master 1
//   rdata               read data, valid only with m0_done/m1_done
//   err                 set with done when the access timed out
//   bus_valid           transaction active toward the decoder
//   bus_we/bus_addr/bus_wdata   latched request presented to the decoder
//   bus_rdata           slave read data, sampled when bus_ready=1
//   bus_ready           slave completes the access in this cycle
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_done,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   output logic                  bus_valid,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  bus_ready
);

   localparam int unsigned            TIMER_W      = $clog2(TIMEOUT + 1);
   localparam logic [TIMER_W-1:0]     TIMER_LAST   = TIMER_W'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0]  TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   grant;
   logic                   winner;
   logic                   owner_q;
   logic                   last_gnt_q;
   logic [TIMER_W-1:0]     timer_q;
   logic                   we_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic                   err_q;
   logic                   timer_expired;

   assign timer_expired = (timer_q == TIMER_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      winner  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               grant = 1'b1;
               // On a tie the master that did not win last time goes next;
               // last_gnt resets to 1 so the first tie favours master 0.
               if (m0_req && m1_req) begin
                  winner = ~last_gnt_q;
               end else begin
                  winner = m1_req;
               end
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (bus_ready || timer_expired) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         timer_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else if (grant) begin
         owner_q    <= winner;
         last_gnt_q <= winner;
         timer_q    <= '0;
         we_q       <= winner ? m1_we    : m0_we;
         addr_q     <= winner ? m1_addr  : m0_addr;
         wdata_q    <= winner ? m1_wdata : m0_wdata;
      end else if (state_q == ST_ACCESS) begin
         // bus_ready takes priority over expiry in the last allowed cycle
         if (bus_ready) begin
            rdata_q <= we_q ? '0 : bus_rdata;
            err_q   <= 1'b0;
         end else if (timer_expired) begin
            rdata_q <= TIMEOUT_DATA;
            err_q   <= 1'b1;
         end else begin
            timer_q <= timer_q + TIMER_W'(1);
         end
      end
   end

   assign bus_valid = (state_q == ST_ACCESS);
   assign bus_we    = we_q & bus_valid;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign m0_done   = (state_q == ST_RESP) && !owner_q;
   assign m1_done   = (state_q == ST_RESP) &&  owner_q;
   assign rdata     = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Randomised bench for mem_bus_arbiter. A stimulus process raises master
//   requests and predicts, from the arbitration rules, which master is served,
//   what the bus must show and what the done response must carry. Those
//   predictions go into queues; separate monitors compare the bus and the
//   done pulses against them. A slave responder answers after a chosen delay.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 16;

   logic          clk;
   logic          reset;
   logic          m0_req, m0_we, m0_done;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m1_req, m1_we, m1_done;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [DW-1:0] rdata;
   logic          err;
   logic          bus_valid, bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;
   logic          bus_ready;

   mem_bus_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_done   (m0_done),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_done   (m1_done),
      .rdata     (rdata),
      .err       (err),
      .bus_valid (bus_valid),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int unsigned   cycles;
   } bus_exp_t;

   typedef struct {
      logic          owner;
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;

   typedef struct {
      int unsigned   w;
      logic [DW-1:0] d;
   } cmd_t;

   bus_exp_t bus_q[$];
   resp_t    resp_q[$];
   cmd_t     cmd_q[$];

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          sb_en = 1'b0;

   // reference model state
   bit          last_gnt;
   bit          pend [2];
   logic        p_we [2];
   logic [AW-1:0] p_addr [2];
   logic [DW-1:0] p_wdata [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic finish_tb();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   endtask

   // ---------------- slave responder ----------------
   bit          r_active = 1'b0;
   int unsigned r_cnt;
   cmd_t        r_cmd;

   always @(negedge clk) begin
      if (bus_valid) begin
         if (!r_active) begin
            r_active = 1'b1;
            r_cnt    = 0;
            if (cmd_q.size() > 0) begin
               r_cmd = cmd_q.pop_front();
            end else begin
               r_cmd.w = 1000;
               r_cmd.d = '0;
            end
         end
         if (r_cnt == r_cmd.w) begin
            bus_ready = 1'b1;
            bus_rdata = r_cmd.d;
         end else begin
            bus_ready = 1'b0;
            bus_rdata = $urandom;
         end
         r_cnt++;
      end else begin
         // noise outside an access must be ignored by the arbiter
         r_active  = 1'b0;
         bus_ready = 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
      end
   end

   // ---------------- bus monitor ----------------
   bit          bv_prev = 1'b0;
   bus_exp_t    cur_bus;
   int unsigned vcnt;

   always @(negedge clk) begin
      if (sb_en) begin
         if (bus_valid) begin
            if (!bv_prev) begin
               vcnt = 0;
               if (bus_q.size() == 0) begin
                  chk("bus_unexpected", 1, 0);
                  cur_bus = '{1'b0, '0, '0, 0};
               end else begin
                  cur_bus = bus_q.pop_front();
               end
            end
            vcnt++;
            chk("bus_addr", bus_addr, cur_bus.addr);
            chk("bus_wdata", bus_wdata, cur_bus.wdata);
            chk("bus_we", bus_we, cur_bus.we);
         end else begin
            chk("bus_we_idle", bus_we, 0);
            if (bv_prev) chk("bus_valid_cycles", vcnt, cur_bus.cycles);
         end
         bv_prev = bus_valid;
      end
   end

   // ---------------- response monitor ----------------
   resp_t cur_resp;

   always @(negedge clk) begin
      if (sb_en) begin
         if (m0_done && m1_done) begin
            chk("both_done", 1, 0);
         end else if (m0_done || m1_done) begin
            if (resp_q.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               cur_resp = resp_q.pop_front();
               chk("done_owner", m1_done, cur_resp.owner);
               chk("resp_rdata", rdata, cur_resp.rdata);
               chk("resp_err", err, cur_resp.err);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic new_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i]    = 1'b1;
      p_we[i]    = we;
      p_addr[i]  = a;
      p_wdata[i] = d;
      if (i == 0) begin
         m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
      end else begin
         m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
      end
   endtask

   task automatic scramble(input bit i);
      if (i == 1'b0) begin
         m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
         if ($urandom_range(0, 3) == 0) m0_req = 1'b0;
      end else begin
         m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
         if ($urandom_range(0, 3) == 0) m1_req = 1'b0;
      end
   endtask

   // Called in an IDLE cycle with at least one master pending; returns in the
   // cycle the winner sees done.
   task automatic run_round(input int unsigned w, input logic [DW-1:0] d, input bit scr);
      bit            win;
      bit            got;
      bit            tmo;
      int unsigned   lat;
      int unsigned   exp_lat;
      logic [DW-1:0] exp_rd;
      if (pend[0] && pend[1]) win = ~last_gnt;
      else                    win = pend[1];
      last_gnt = win;
      tmo      = (w >= TO);
      exp_rd   = tmo ? 32'hDEAD_BEEF : (p_we[win] ? '0 : d);
      exp_lat  = 2 + (tmo ? TO - 1 : w);
      bus_q.push_back('{p_we[win], p_addr[win], p_wdata[win], (tmo ? TO : w + 1)});
      cmd_q.push_back('{w, d});
      resp_q.push_back('{win, exp_rd, tmo});
      got = 1'b0;
      lat = 0;
      for (int k = 0; k < int'(TO) + 8; k++) begin
         @(negedge clk);
         lat++;
         if ((win ? m1_done : m0_done) === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (scr && $urandom_range(0, 1) == 1) scramble(win);
      end
      chk("done_seen", got, 1);
      if (!got) finish_tb();
      chk("done_latency", lat, exp_lat);
      if (win) m1_req = 1'b0;
      else     m0_req = 1'b0;
      pend[win] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      chk("global_timeout", 1, 0);
      finish_tb();
   end

   initial begin
      bit got;
      int unsigned w;
      reset  = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      bus_ready = 1'b0; bus_rdata = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      last_gnt = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_m0_done", m0_done, 0);
      chk("rst_m1_done", m1_done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_bus_valid", bus_valid, 0);
      chk("post_rst_done", {m1_done, m0_done}, 0);

      // reset in the middle of an access aborts it silently
      m0_we = 1'b1; m0_addr = 32'h0000_0040; m0_wdata = 32'hCAFE_0001; m0_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("mid_rst_reach_access", got, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_bus_valid", bus_valid, 0);
      chk("mid_rst_bus_we", bus_we, 0);
      chk("mid_rst_bus_addr", bus_addr, 0);
      chk("mid_rst_bus_wdata", bus_wdata, 0);
      m0_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_done", {m1_done, m0_done}, 0);
      end
      reset    = 1'b1;
      last_gnt = 1'b1;
      sb_en    = 1'b1;

      // continuous contention: expect 0,1,0,1
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (!pend[i]) new_req(i, 1'($urandom), $urandom, $urandom);
         run_round(0, $urandom, 1'b0);
      end
      // drain the remaining pending master
      @(negedge clk);
      run_round(1, $urandom, 1'b0);

      // m0 write, ready in first access cycle
      @(negedge clk);
      new_req(0, 1'b1, 32'h7FFF_EF00, 32'h1234_5678);
      run_round(0, $urandom, 1'b0);

      // m1 read, three wait cycles
      @(negedge clk);
      new_req(1, 1'b0, 32'h1001_0024, 32'h0);
      run_round(3, 32'hA5A5_0001, 1'b0);

      // slave never answers
      @(negedge clk);
      new_req(0, 1'b0, 32'h2000_0000, 32'h0);
      run_round(TO + 5, 32'h1111_2222, 1'b0);

      // next one after the timeout is normal
      @(negedge clk);
      new_req(1, 1'b0, 32'h2000_0004, 32'h0);
      run_round(1, 32'h3333_4444, 1'b0);

      // ready on the very last allowed cycle still wins
      @(negedge clk);
      new_req(0, 1'b0, 32'h2000_0008, 32'h0);
      run_round(TO - 1, 32'h5555_6666, 1'b0);

      // master inputs change while the access is running
      @(negedge clk);
      new_req(0, 1'b1, 32'h3000_0010, 32'hBEEF_0010);
      run_round(4, $urandom, 1'b1);

      // randomised traffic
      for (int r = 0; r < 300; r++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1)
               new_req(i, 1'($urandom), $urandom, $urandom);
         if (pend[0] || pend[1]) begin
            if ($urandom_range(0, 7) == 0) w = $urandom_range(TO - 2, TO + 2);
            else                           w = $urandom_range(0, 4);
            run_round(w, $urandom, 1'($urandom));
         end
      end
      while (pend[0] || pend[1]) begin
         @(negedge clk);
         run_round(0, $urandom, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("bus_q_drained", bus_q.size(), 0);
      chk("resp_q_drained", resp_q.size(), 0);
      finish_tb();
   end

endmodule
